// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting the common data bus to one of NUM_FU functional units.
// Combinational one-hot ack to the winner; the broadcast is registered one cycle later.
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 5,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PTR_W  = $clog2(NUM_FU)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     squash,
  input  logic [NUM_FU-1:0]        fu_done,
  input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
  input  logic [NUM_FU*XLEN-1:0]   fu_value,
  output logic [NUM_FU-1:0]        ack,
  output logic                     cdb_valid,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [XLEN-1:0]          cdb_value,
  output logic [PTR_W-1:0]         cdb_fu
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] cand;
  logic             grant_valid;
  logic             take;
  logic [TAG_W-1:0] grant_tag;
  logic [XLEN-1:0]  grant_value;
  int unsigned      idx;

  // Search from ptr upward, wrapping modulo NUM_FU rather than 2^PTR_W.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    idx         = 0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      cand = idx[PTR_W-1:0];
      if (!grant_valid && fu_done[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    grant_tag   = '0;
    grant_value = '0;
    for (int unsigned j = 0; j < NUM_FU; j++) begin
      if (grant_idx == PTR_W'(j)) begin
        grant_tag   = fu_tag[j*TAG_W +: TAG_W];
        grant_value = fu_value[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    next_ptr = (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    take     = grant_valid && !squash;
  end

  always_comb begin
    ack = '0;
    if (reset && take) ack[grant_idx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_fu    <= '0;
    end else begin
      cdb_valid <= take;
      if (take) begin
        ptr       <= next_ptr;
        cdb_tag   <= grant_tag;
        cdb_value <= grant_value;
        cdb_fu    <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, single FU, round-robin wrap,
// contention, squash and asynchronous reset mid-stream.
module tb_cdb_arbiter;

  localparam int unsigned NUM_FU = 5;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned PTR_W  = 3;

  logic                    clock;
  logic                    reset;
  logic                    squash;
  logic [NUM_FU-1:0]       fu_done;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       ack;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic [PTR_W-1:0]        cdb_fu;

  int compared   = 0;
  int mismatched = 0;

  cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) u_dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_done(fu_done), .fu_tag(fu_tag), .fu_value(fu_value),
    .ack(ack), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .cdb_fu(cdb_fu)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
    fu_tag[i*TAG_W +: TAG_W] = t;
    fu_value[i*XLEN +: XLEN] = v;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Requester contract: a pending, un-acked request must stay stable.
  logic [NUM_FU-1:0]       p_done, p_ack;
  logic [NUM_FU*TAG_W-1:0] p_tag;
  logic [NUM_FU*XLEN-1:0]  p_val;
  logic                    p_rst = 1'b0;
  always @(posedge clock) begin
    if (reset && p_rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (p_done[i] && !p_ack[i]) begin
          assert (fu_done[i] && fu_tag[i*TAG_W +: TAG_W] == p_tag[i*TAG_W +: TAG_W]
                  && fu_value[i*XLEN +: XLEN] == p_val[i*XLEN +: XLEN])
            else $error("requester contract broken on FU %0d", i);
        end
      end
    end
    p_done <= fu_done;
    p_ack  <= ack;
    p_tag  <= fu_tag;
    p_val  <= fu_value;
    p_rst  <= reset;
  end

  int               acks [NUM_FU];
  logic [TAG_W-1:0] exp_tag;
  logic [XLEN-1:0]  exp_val;
  int               g;
  int               rnd;

  initial begin
    reset    = 1'b0;
    squash   = 1'b0;
    fu_done  = '1;
    fu_tag   = '0;
    fu_value = '0;
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, TAG_W'(i + 1), XLEN'(100 + i));

    // Reset with every FU requesting, then drain in order 0..4
    tick;
    check("rst_ack", ack, 5'b00000);
    check("rst_valid", cdb_valid, 1'b0);
    check("rst_tag", cdb_tag, 5'd0);
    check("rst_fu", cdb_fu, 3'd0);
    reset = 1'b1;
    #1;
    check("rel_ack0", ack, 5'b00001);
    for (int i = 0; i < NUM_FU; i++) begin
      tick;
      check("rel_valid", cdb_valid, 1'b1);
      check("rel_tag", cdb_tag, 64'(i + 1));
      check("rel_value", cdb_value, 64'(100 + i));
      check("rel_fu", cdb_fu, 64'(i));
      fu_done[i] = 1'b0;
      #1;
      check("rel_ack", ack, (i == NUM_FU - 1) ? 64'd0 : 64'(1) << (i + 1));
    end
    tick;
    check("rel_idle_valid", cdb_valid, 1'b0);
    check("rel_idle_tag_hold", cdb_tag, 5'd5);
    check("rel_idle_fu_hold", cdb_fu, 3'd4);

    // Round robin: two rounds, each FU re-requests once with a fresh tag
    for (int i = 0; i < NUM_FU; i++) acks[i] = 0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        rnd = (c > i) ? 1 : 0;
        fu_done[i] = (c < 5) || (i >= c - 5);
        drive_fu(i, TAG_W'(rnd * 8 + i + 1), XLEN'(rnd * 1000 + i * 17 + 3));
      end
      g = c % NUM_FU;
      rnd = (c > g) ? 1 : 0;
      exp_tag = TAG_W'(rnd * 8 + g + 1);
      exp_val = XLEN'(rnd * 1000 + g * 17 + 3);
      #1;
      check("rr_ack", ack, 64'(1) << g);
      for (int i = 0; i < NUM_FU; i++) if (ack[i]) acks[i]++;
      tick;
      check("rr_valid", cdb_valid, 1'b1);
      check("rr_tag", cdb_tag, exp_tag);
      check("rr_value", cdb_value, exp_val);
      check("rr_fu", cdb_fu, 64'(g));
    end
    for (int i = 0; i < NUM_FU; i++) check("rr_ack_count", 64'(acks[i]), 64'd2);
    fu_done = '0;
    #1;
    check("rr_idle_ack", ack, 5'b00000);
    tick;
    check("rr_idle_valid", cdb_valid, 1'b0);

    // Single FU: FU1, tag 3, value 5
    drive_fu(1, 5'd3, 32'd5);
    fu_done = 5'b00010;
    #1;
    check("single_ack", ack, 5'b00010);
    tick;
    check("single_valid", cdb_valid, 1'b1);
    check("single_tag", cdb_tag, 5'd3);
    check("single_value", cdb_value, 32'd5);
    check("single_fu", cdb_fu, 3'd1);
    fu_done = '0;
    #1;
    check("single_idle_ack", ack, 5'b00000);
    tick;
    check("single_idle_valid", cdb_valid, 1'b0);
    check("single_idle_tag_hold", cdb_tag, 5'd3);

    // Contention: move ptr to 3 via FU2, then FU2 and FU4 compete
    drive_fu(2, 5'd9, 32'd90);
    fu_done = 5'b00100;
    #1;
    check("cont_setup_ack", ack, 5'b00100);
    tick;
    check("cont_setup_tag", cdb_tag, 5'd9);
    drive_fu(2, 5'd12, 32'd120);
    drive_fu(4, 5'd14, 32'd140);
    fu_done = 5'b10100;
    #1;
    check("cont_ack_first", ack, 5'b10000);
    tick;
    check("cont_tag_first", cdb_tag, 5'd14);
    check("cont_fu_first", cdb_fu, 3'd4);
    fu_done = 5'b00100;
    #1;
    check("cont_ack_second", ack, 5'b00100);
    tick;
    check("cont_valid_second", cdb_valid, 1'b1);
    check("cont_tag_second", cdb_tag, 5'd12);
    check("cont_value_second", cdb_value, 32'd120);

    // Squash with FU0, FU2, FU4 pending; ptr must stay at 3
    squash = 1'b1;
    drive_fu(0, 5'd20, 32'd200);
    drive_fu(2, 5'd22, 32'd220);
    drive_fu(4, 5'd24, 32'd240);
    fu_done = 5'b10101;
    #1;
    check("squash_ack", ack, 5'b00000);
    tick;
    check("squash_valid", cdb_valid, 1'b0);
    check("squash_tag_hold", cdb_tag, 5'd12);
    check("squash_fu_hold", cdb_fu, 3'd2);
    squash = 1'b0;
    #1;
    check("post_squash_ack", ack, 5'b10000);
    tick;
    check("post_squash_tag", cdb_tag, 5'd24);
    fu_done = 5'b00101;
    #1;
    check("post_squash_ack0", ack, 5'b00001);
    tick;
    check("post_squash_tag0", cdb_tag, 5'd20);
    check("post_squash_fu0", cdb_fu, 3'd0);
    fu_done = 5'b00100;
    #1;
    check("post_squash_ack2", ack, 5'b00100);
    tick;
    check("post_squash_tag2", cdb_tag, 5'd22);

    // Asynchronous reset between edges while a broadcast is live
    drive_fu(1, 5'd7, 32'd70);
    fu_done = 5'b00010;
    #1;
    check("async_pre_ack", ack, 5'b00010);
    tick;
    check("async_pre_valid", cdb_valid, 1'b1);
    check("async_pre_tag", cdb_tag, 5'd7);
    drive_fu(0, 5'd1, 32'd11);
    drive_fu(3, 5'd3, 32'd33);
    fu_done = 5'b01001;
    #1;
    check("async_ptr2_ack", ack, 5'b01000);
    reset = 1'b0;
    #1;
    check("async_valid", cdb_valid, 1'b0);
    check("async_tag", cdb_tag, 5'd0);
    check("async_value", cdb_value, 32'd0);
    check("async_fu", cdb_fu, 3'd0);
    check("async_ack", ack, 5'b00000);
    reset = 1'b1;
    #1;
    check("async_release_ack", ack, 5'b00001);
    tick;
    check("async_release_valid", cdb_valid, 1'b1);
    check("async_release_fu", cdb_fu, 3'd0);
    check("async_release_tag", cdb_tag, 5'd1);
    fu_done = 5'b01000;
    #1;
    check("async_final_ack", ack, 5'b01000);
    tick;
    fu_done = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
